// File: rtl/ama_riscv_pkg.sv
// Shared types for the DMEM arbiter: arbitration FSM states and read-data owner.
package ama_riscv_pkg;

  typedef enum logic [1:0] {
    S_CORE  = 2'd0,  // core has priority, loader uses idle slots
    S_LOAD  = 2'd1,  // loader owns the port under lock
    S_FORCE = 2'd2   // one loader slot is owed after starvation
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LD   = 1'b1
  } owner_t;

endpackage

// File: rtl/ama_riscv_dmem_arbiter_if.sv
// Bus bundle between the core load/store path, the loader and DMEM.
//
// Handshake: a master presents a request (core_en / ld_req with we/addr/wdata)
// and must hold it stable until it is taken. The core request is taken in any
// cycle with core_en=1 and core_stall=0; the loader request is taken in any
// cycle with ld_gnt=1. A taken read returns data one cycle later, qualified by
// core_rvalid / ld_rvalid. Writes never produce rvalid.
interface ama_riscv_dmem_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 32
);
  logic          core_en;
  logic [3:0]    core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_stall;
  logic [DW-1:0] core_rdata;
  logic          core_rvalid;

  logic          ld_req;
  logic          ld_lock;
  logic [3:0]    ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic [DW-1:0] ld_rdata;
  logic          ld_rvalid;

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  core_en, core_we, core_addr, core_wdata,
    input  ld_req, ld_lock, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output core_stall, core_rdata, core_rvalid,
    output ld_gnt, ld_rdata, ld_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment side: masters plus memory
  modport master (
    output core_en, core_we, core_addr, core_wdata,
    output ld_req, ld_lock, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  core_stall, core_rdata, core_rvalid,
    input  ld_gnt, ld_rdata, ld_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ama_riscv_sat_cnt.sv
// Saturating up-counter with clear. Clear restarts the count and still counts
// the current cycle when inc is set, so a run that begins this cycle reads 1.
// o_hit_next flags that this cycle's update makes the count reach MAX.
module ama_riscv_sat_cnt #(
  parameter int W   = 8,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_hit_next
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  // Count state: clear/restart, otherwise increment up to MAX and hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_hit_next = i_inc && (i_clr ? (MAX_V == W'(1)) : (r_cnt >= (MAX_V - W'(1))));

endmodule

// File: rtl/ama_riscv_dmem_arbiter.sv
// Shares the single DMEM port between the core and a secondary loader master.
// Core has default priority; the loader is guaranteed a slot after MAX_WAIT
// denied cycles and may lock the port for up to MAX_LOCK cycles, after which
// the core gets one priority slot. The request path is a pure mux.
module ama_riscv_dmem_arbiter
  import ama_riscv_pkg::*;
#(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8,
  parameter int MAX_LOCK = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  ama_riscv_dmem_arbiter_if.slave   bus,
  output arb_state_t                o_dbg_state,
  output logic [7:0]                o_dbg_wait_cnt,
  output logic [7:0]                o_dbg_lock_cnt
);

  arb_state_t    r_state;
  owner_t        r_owner;
  logic          r_rd_pending;

  logic          w_core_gnt;
  logic          w_ld_gnt;
  logic          w_wait_hit;
  logic          w_lock_hit;
  logic          w_lock_stay;
  logic [3:0]    w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  // Core is only ever served in S_CORE; the loader takes every other state.
  assign w_core_gnt = (r_state == S_CORE) && bus.core_en;
  assign w_ld_gnt   = bus.ld_req && ((r_state != S_CORE) || !bus.core_en);

  // Lock is kept only while the burst has not used up its MAX_LOCK slots.
  assign w_lock_stay = w_ld_gnt && bus.ld_lock && !w_lock_hit;

  // With no grant the address/data lines idle on the core values.
  assign w_mem_we    = w_ld_gnt ? bus.ld_we : (w_core_gnt ? bus.core_we : 4'b0);
  assign w_mem_addr  = w_ld_gnt ? bus.ld_addr  : bus.core_addr;
  assign w_mem_wdata = w_ld_gnt ? bus.ld_wdata : bus.core_wdata;

  assign bus.mem_en    = w_core_gnt | w_ld_gnt;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  assign bus.core_stall = bus.core_en && !w_core_gnt;
  assign bus.ld_gnt     = w_ld_gnt;

  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.ld_rdata    = bus.mem_rdata;
  assign bus.core_rvalid = r_rd_pending && (r_owner == OWN_CORE);
  assign bus.ld_rvalid   = r_rd_pending && (r_owner == OWN_LD);

  // Starvation counter: consecutive cycles the loader asked and was refused
  ama_riscv_sat_cnt #(.W(8), .MAX(MAX_WAIT)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (!bus.ld_req || w_ld_gnt),
    .i_inc      (bus.ld_req && !w_ld_gnt),
    .o_cnt      (o_dbg_wait_cnt),
    .o_hit_next (w_wait_hit)
  );

  // Burst length counter: the grant that opens a lock counts as the first slot
  ama_riscv_sat_cnt #(.W(8), .MAX(MAX_LOCK)) u_lock_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state != S_LOAD),
    .i_inc      (w_ld_gnt),
    .o_cnt      (o_dbg_lock_cnt),
    .o_hit_next (w_lock_hit)
  );

  // Arbitration FSM plus read-return tracking (owner and pending read flag)
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_CORE;
      r_owner      <= OWN_CORE;
      r_rd_pending <= 1'b0;
    end else begin
      r_rd_pending <= bus.mem_en && (w_mem_we == 4'b0);
      r_owner      <= w_ld_gnt ? OWN_LD : OWN_CORE;
      case (r_state)
        S_CORE: begin
          if (w_lock_stay) begin
            r_state <= S_LOAD;
          end else if (w_wait_hit) begin
            r_state <= S_FORCE;
          end
        end
        S_FORCE: r_state <= w_lock_stay ? S_LOAD : S_CORE;
        S_LOAD:  r_state <= w_lock_stay ? S_LOAD : S_CORE;
        default: r_state <= S_CORE;
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule
